// File: rtl/mux_arb_pkg.sv
// mux_arb_pkg
// Shared definitions for the two-source round-robin mux arbiter.
//   state_e       : arbiter FSM states (IDLE, GX, GY)
//   src_e         : identity of the most recently served source
//   DEFAULT_WIDTH : default data width of the shared mux path
package mux_arb_pkg;

  localparam int DEFAULT_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GX   = 2'd1,
    GY   = 2'd2
  } state_e;

  typedef enum logic {
    SRC_X = 1'b0,
    SRC_Y = 1'b1
  } src_e;

endpackage

// File: rtl/mux_arbiter_mux2_reg.sv
// mux2_reg
// WIDTH-bit 2-to-1 multiplexer followed by an output register and a valid flag.
// Ports:
//   clk, rst_n : clock and asynchronous active-low reset
//   en         : capture enable; q_valid follows it one cycle later
//   sel        : 1 selects a, 0 selects b
//   a, b       : data inputs
//   q          : registered selected data, holds its value while en is low
//   q_valid    : high when q was captured on the previous edge
module mux2_reg #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             sel,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] q,
  output logic             q_valid
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q       <= '0;
      q_valid <= 1'b0;
    end else begin
      q_valid <= en;
      if (en) begin
        q <= sel ? a : b;
      end
    end
  end

endmodule

// File: rtl/mux_arbiter.sv
// mux_arbiter
// Round-robin arbiter sharing a WIDTH-bit 2-to-1 mux between sources X and Y.
// Grants, select and data are all registered; data lags the grant by one cycle.
// Ports:
//   clk, rst_n     : clock and asynchronous active-low reset
//   req_x, req_y   : source requests
//   x, y           : source data
//   gnt_x, gnt_y   : registered grants (never both high)
//   s              : mux select, 1 = x, 0 = y; holds while idle
//   m, m_valid     : registered selected data and its valid flag
//   LED            : combinational mirror of m
// Optional feature: define MUXARB_MAXHOLD_EN to bound a grant to MAX_HOLD
// cycles whenever the other source is waiting.
module mux_arbiter
  import mux_arb_pkg::*;
#(
  parameter int WIDTH    = DEFAULT_WIDTH,
  parameter int MAX_HOLD = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_x,
  input  logic             req_y,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic             gnt_x,
  output logic             gnt_y,
  output logic             s,
  output logic [WIDTH-1:0] m,
  output logic             m_valid,
  output logic [WIDTH-1:0] LED
);

  localparam logic [1:0] ST_IDLE = IDLE;
  localparam logic [1:0] ST_GX   = GX;
  localparam logic [1:0] ST_GY   = GY;

  // Counter value at which the owner has held the grant for MAX_HOLD cycles.
  localparam logic [7:0] HOLD_LIMIT = 8'(MAX_HOLD - 1);

  logic [1:0] state_reg;
  logic [1:0] state_next;
  src_e       last_reg;
  logic       hold_expired;

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: begin
        if (req_x && req_y) begin
          // Tie: serve whoever was not served last.
          state_next = (last_reg == SRC_Y) ? ST_GX : ST_GY;
        end else if (req_x) begin
          state_next = ST_GX;
        end else if (req_y) begin
          state_next = ST_GY;
        end
      end
      ST_GX: begin
        // Hand over directly to a waiting Y so there is no idle bubble.
        if (!req_x) begin
          state_next = req_y ? ST_GY : ST_IDLE;
        end else if (req_y && hold_expired) begin
          state_next = ST_GY;
        end
      end
      ST_GY: begin
        if (!req_y) begin
          state_next = req_x ? ST_GX : ST_IDLE;
        end else if (req_x && hold_expired) begin
          state_next = ST_GX;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
      last_reg  <= SRC_Y;
      gnt_x     <= 1'b0;
      gnt_y     <= 1'b0;
      s         <= 1'b0;
    end else begin
      state_reg <= state_next;
      gnt_x     <= (state_next == ST_GX);
      gnt_y     <= (state_next == ST_GY);
      // Grant states are only reachable through a transition or a hold, so
      // writing last on every grant cycle is the same as writing it on entry.
      if (state_next == ST_GX) begin
        last_reg <= SRC_X;
        s        <= 1'b1;
      end else if (state_next == ST_GY) begin
        last_reg <= SRC_Y;
        s        <= 1'b0;
      end
    end
  end

`ifdef MUXARB_MAXHOLD_EN
  logic [7:0] hold_reg;

  // Cleared on every state change (covers each grant entry); counts granted
  // cycles and parks at HOLD_LIMIT until the other side asks for the mux.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_reg <= '0;
    end else if (state_next != state_reg) begin
      hold_reg <= '0;
    end else if ((state_reg != ST_IDLE) && (hold_reg != HOLD_LIMIT)) begin
      hold_reg <= hold_reg + 8'd1;
    end
  end

  assign hold_expired = (hold_reg == HOLD_LIMIT);
`else
  // No hold counter: the owner keeps the mux until it drops its request.
  // HOLD_LIMIT is folded into a sink so the parameter is still referenced.
  logic unused_hold_limit;
  assign unused_hold_limit = ^HOLD_LIMIT;
  assign hold_expired      = 1'b0;
`endif

  // Data is captured in every granted cycle using the already-registered select.
  mux2_reg #(
    .WIDTH (WIDTH)
  ) u_mux2_reg (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (gnt_x | gnt_y),
    .sel     (s),
    .a       (x),
    .b       (y),
    .q       (m),
    .q_valid (m_valid)
  );

  assign LED = m;

endmodule

// File: tb/tb_mux_arbiter.sv
module tb_mux_arbiter;

  localparam int WIDTH    = 4;
  localparam int MAX_HOLD = 4;
`ifdef MUXARB_MAXHOLD_EN
  localparam bit HOLD_EN = 1'b1;
`else
  localparam bit HOLD_EN = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst_n;
  logic             req_x, req_y;
  logic [WIDTH-1:0] x, y;
  logic             gnt_x, gnt_y, s, m_valid;
  logic [WIDTH-1:0] m, LED;

  int checks = 0;
  int passes = 0;

  // Reference model: who owns the mux (0 none, 1 X, 2 Y), who was served
  // last, how many cycles the owner has had, and what the data path shows.
  int               owner;
  int               last_src;
  int               held;
  logic             sel_e;
  logic [WIDTH-1:0] m_e;
  logic             mv_e;

  mux_arbiter #(
    .WIDTH    (WIDTH),
    .MAX_HOLD (MAX_HOLD)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req_x   (req_x),
    .req_y   (req_y),
    .x       (x),
    .y       (y),
    .gnt_x   (gnt_x),
    .gnt_y   (gnt_y),
    .s       (s),
    .m       (m),
    .m_valid (m_valid),
    .LED     (LED)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    owner    = 0;
    last_src = 2;
    held     = 0;
    sel_e    = 1'b0;
    m_e      = '0;
    mv_e     = 1'b0;
  endtask

  // Advance the model across one rising edge using the inputs present there.
  task automatic model_edge();
    int nxt;
    if (!rst_n) begin
      model_reset();
      return;
    end
    if (owner != 0) begin
      m_e  = sel_e ? x : y;
      mv_e = 1'b1;
    end else begin
      mv_e = 1'b0;
    end
    nxt = owner;
    if (owner == 0) begin
      if (req_x && req_y) nxt = (last_src == 1) ? 2 : 1;
      else if (req_x)     nxt = 1;
      else if (req_y)     nxt = 2;
    end else if (owner == 1) begin
      if (!req_x) nxt = req_y ? 2 : 0;
      else if (HOLD_EN && req_y && held >= MAX_HOLD) nxt = 2;
    end else begin
      if (!req_y) nxt = req_x ? 1 : 0;
      else if (HOLD_EN && req_x && held >= MAX_HOLD) nxt = 1;
    end
    if (nxt != 0 && nxt == owner) held++;
    else held = (nxt != 0) ? 1 : 0;
    if (nxt != 0 && nxt != owner) last_src = nxt;
    owner = nxt;
    if (owner == 1) sel_e = 1'b1;
    else if (owner == 2) sel_e = 1'b0;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic check_all(input string tag);
    check({tag, ".gnt_x"},   32'(gnt_x),   32'(owner == 1));
    check({tag, ".gnt_y"},   32'(gnt_y),   32'(owner == 2));
    check({tag, ".s"},       32'(s),       32'(sel_e));
    check({tag, ".m"},       32'(m),       32'(m_e));
    check({tag, ".m_valid"}, 32'(m_valid), 32'(mv_e));
    check({tag, ".LED"},     32'(LED),     32'(m_e));
  endtask

  task automatic tick(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    check_all(tag);
    $display("%0t %s req=%b%b x=%h y=%h gnt=%b%b s=%b m=%h v=%b",
             $time, tag, req_x, req_y, x, y, gnt_x, gnt_y, s, m, m_valid);
  endtask

  task automatic async_reset(input string tag);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all(tag);
    $display("%0t %s async reset gnt=%b%b s=%b m=%h v=%b", $time, tag, gnt_x, gnt_y, s, m, m_valid);
  endtask

  task automatic release_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int n_gx;
    bit run;

    model_reset();
    rst_n = 1'b0; req_x = 1'b1; req_y = 1'b0; x = 4'b1010; y = 4'b0101;

    // Reset held with a live request: everything stays cleared.
    tick("rst0");
    check("rst0.m_const", 32'(m), 32'h0);
    tick("rst1");
    release_reset();

    // Single requester X.
    tick("single.grant");
    check("single.gnt_x_const", 32'(gnt_x), 32'h1);
    tick("single.data");
    check("single.m_const", 32'(m), 32'hA);
    req_x = 1'b0;
    tick("single.idle");
    tick("single.valid_fall");

    // Tie right after reset goes to X, then handover to Y without a gap.
    async_reset("tie.rst");
    release_reset();
    req_x = 1'b1; req_y = 1'b1;
    tick("tie.grant");
    check("tie.gnt_x_const", 32'(gnt_x), 32'h1);
    tick("tie.data_x");
    req_x = 1'b0;
    tick("tie.swap");
    tick("tie.data_y");
    check("tie.m_const", 32'(m), 32'h5);

    // Round-robin from IDLE.
    req_y = 1'b0;
    tick("rr.idle0");
    req_x = 1'b1;
    tick("rr.x_only");
    req_x = 1'b0;
    tick("rr.idle1");
    req_x = 1'b1; req_y = 1'b1;
    tick("rr.tie_y");
    check("rr.gnt_y_const", 32'(gnt_y), 32'h1);
    req_x = 1'b0; req_y = 1'b0;
    tick("rr.idle2");
    req_x = 1'b1; req_y = 1'b1;
    tick("rr.tie_x");

    // Mid-grant reset while Y owns the mux with m=1100.
    req_x = 1'b0; req_y = 1'b1; y = 4'b1100;
    tick("mid.gy");
    tick("mid.data");
    async_reset("mid.rst");
    req_y = 1'b0; req_x = 1'b1;
    release_reset();
    tick("mid.resume_gx");

    // Hold limit: X keeps its request while Y waits.
    async_reset("hold.rst");
    release_reset();
    req_x = 1'b1; req_y = 1'b0;
    tick("hold.gx");
    req_y = 1'b1;
    n_gx = 1;
    run  = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick("hold.run");
      if (run && gnt_x) n_gx++;
      else run = 1'b0;
    end
    check("hold.gnt_x_cycles", 32'(n_gx), HOLD_EN ? 32'(MAX_HOLD) : 32'd21);

    // Randomized traffic with occasional reset.
    for (int i = 0; i < 400; i++) begin
      req_x = ($urandom_range(0, 9) < 6);
      req_y = ($urandom_range(0, 9) < 6);
      x     = WIDTH'($urandom);
      y     = WIDTH'($urandom);
      rst_n = ($urandom_range(0, 49) != 0);
      tick("rand");
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/mux_arbiter.md
# mux_arbiter

Two-requester round-robin arbiter that shares a WIDTH-bit 2-to-1 multiplexer between source X and source Y. It issues request/grant handshakes, drives the mux select `s`, and registers the selected data onto `m` with a valid flag and an LED mirror. It sits directly in front of the existing x/y/s/m/LED mux datapath and replaces the manual select switch with a sequenced controller.

## Interface
- `WIDTH`, 4, data width of x, y, m, LED
- `MAX_HOLD`, 8, maximum grant length in cycles while the other side is waiting; used only with `MUXARB_MAXHOLD_EN`; legal range 2..255
- `clk` input 1: single clock, rising edge
- `rst_n` input 1: reset, asynchronous, active-low
- `req_x` input 1: source X requests the mux
- `req_y` input 1: source Y requests the mux
- `x` input WIDTH: source X data
- `y` input WIDTH: source Y data
- `gnt_x` output 1: X owns the mux (registered)
- `gnt_y` output 1: Y owns the mux (registered)
- `s` output 1: mux select; 1 = x, 0 = y (registered)
- `m` output WIDTH: registered selected data
- `m_valid` output 1: `m` holds granted-source data
- `LED` output WIDTH: mirror of `m`

## Operation
- FSM states: IDLE, GX, GY. `last` register records the most recently served source.
- IDLE: only req_x -> GX; only req_y -> GY; both -> source not equal to `last`; none -> stay.
- GX: gnt_x=1, s=1. If req_x drops: req_y high -> GY directly (no idle bubble), else IDLE. GY symmetric, with s=0.
- `last` updates on every entry to GX/GY.
- In IDLE: gnt_x=gnt_y=0, `s` holds its last value, m_valid=0, `m` holds last data.
- Datapath: each cycle in GX/GY, m <= (s ? x : y); m_valid <= 1. LED = m (combinational copy).
- Never both grants high; gnt_x implies s=1, gnt_y implies s=0.
- Without `MUXARB_MAXHOLD_EN` the owner keeps the grant as long as its req stays high (starvation possible; by design).
- Reset values: state IDLE, last = Y (so X wins the first tie), gnt_x=0, gnt_y=0, s=0, m=0, m_valid=0, LED=0.

## Timing
- req sampled at edge E -> gnt/s change at E; m/m_valid reflect that source at E+1 (one-cycle data latency after grant).
- Owner drops req before edge E with other req high -> grant swaps at E; m switches source at E+1; m_valid stays 1 throughout handover.
- Both reqs drop before E -> IDLE at E; m_valid falls at E+1.
- Simultaneous first request from IDLE -> tie broken by `last`, never both granted.
- rst_n low at any time -> all outputs to reset values immediately, without waiting for clk; operation resumes from IDLE on the first edge after release.

## Configuration
- `MUXARB_MAXHOLD_EN` defined: an 8-bit hold counter clears on every grant entry and increments each granted cycle. When the counter reaches MAX_HOLD-1 and the other req is high, the grant transfers at the next edge even if the owner's req is still high; `last` updates. If the other req is low, the counter saturates and the owner keeps the grant.
- Undefined: no counter is instantiated; grant is released only by deassertion of the owner's req.

## Structure
- Package `mux_arb_pkg`: state enum (IDLE, GX, GY), source enum for `last` (SRC_X, SRC_Y), default WIDTH constant.
- Sub-module `mux2_reg`: WIDTH-bit 2-to-1 mux with output register and valid flag. The arbiter contains the FSM, `last`, and the optional hold counter.

## Test plan
- Reset: hold rst_n=0 with x=1010, y=0101, req_x=1 -> gnt_x=gnt_y=0, s=0, m=0000, m_valid=0, LED=0000; the asynchronous clear is visible mid-cycle.
- Single requester: req_x=1, x=1010 -> gnt_x=1 and s=1 at the first edge; m=1010 and m_valid=1 one edge later; LED=1010.
- Tie after reset: req_x=req_y=1 simultaneously -> X granted first; X drops req -> GY at the next edge; m=y=0101 one edge later, with no m_valid gap.
- Round-robin: alternate X-only, then both reqs together from IDLE -> Y granted (last=X); repeat -> grants alternate X/Y.
- Mid-grant reset: GY active with m=1100 -> pulse rst_n low -> immediate reset values; after release, req_x=1 -> GX.
- With `MUXARB_MAXHOLD_EN`, MAX_HOLD=4: req_x held high, req_y raised -> grant moves to Y after exactly 4 gnt_x cycles. Without the macro, the same stimulus keeps gnt_x=1 indefinitely.
